valid_delay_pipe: RTL and testbench
===================================

VALID_DELAY_PIPE -- requirements
Module: valid_delay_pipe

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of register stages, >=1.
REQ-002 The block SHALL have parameter WIDTH, default 8: data bus width, >=1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: advance enable; 1 shifts the pipe, 0 holds it.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous clear of all stage valid flags.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data qualifier.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: data word entering stage 1.
REQ-009 The block SHALL have port dly_sel, input, $clog2(DEPTH+1) bits: runtime output tap, 0..DEPTH.
REQ-010 The block SHALL have port out_valid, output, 1 bit: valid flag at the selected tap.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: data at the selected tap.
REQ-012 The block SHALL have port valid_cnt, output, $clog2(DEPTH+1) bits: number of valid entries held in stages 1..DEPTH.

Function
REQ-013 The block SHALL hold DEPTH stages, each a valid bit plus a WIDTH-bit data register; stage 0 is the input (in_valid, in_data).
REQ-014 When en=1 and flush=0 on a clock edge, stage k SHALL load stage k-1 for k=1..DEPTH, and stage 1 SHALL load in_valid/in_data.
REQ-015 On that advance, the data register SHALL load 0 when the incoming valid is 0, so invalid stages always hold zero data.
REQ-016 When en=0 and flush=0, all stages SHALL hold; an input presented on that cycle SHALL be dropped.
REQ-017 When flush=1, all valid bits and data registers SHALL clear to 0 on the edge regardless of en, and in_valid on the same cycle SHALL be dropped.
REQ-018 out_valid/out_data SHALL be driven combinationally from stage dly_sel, giving a latency of dly_sel advancing cycles.
REQ-019 With dly_sel=0, out_valid=in_valid and out_data SHALL equal in_data when in_valid=1, else 0; the path is combinational.
REQ-020 A dly_sel value greater than DEPTH SHALL be clamped to DEPTH.
REQ-021 out_data SHALL be 0 whenever out_valid=0.
REQ-022 A dly_sel change SHALL take effect combinationally in the same cycle; entries already in the pipe are not moved or lost.
REQ-023 valid_cnt SHALL be registered and equal the popcount of the stage 1..DEPTH valid bits after each edge.
REQ-024 valid_cnt SHALL be maintained incrementally: +1 when a valid enters and none exits stage DEPTH, -1 for the reverse, unchanged otherwise, and 0 on flush.
REQ-025 valid_cnt SHALL never exceed DEPTH; a full pipe with continuous valid input SHALL stay at DEPTH.

Reset
REQ-026 While rst=0, all stage valid bits, data registers and valid_cnt SHALL be 0 immediately, without waiting for a clock edge.
REQ-027 While rst=0, out_valid=0 and out_data=0 for dly_sel>=1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight entries.
REQ-029 After rst is released, the first advance SHALL occur on the first rising edge with en=1.

Verification (DEPTH=4, WIDTH=8)
REQ-030 Bench: dly_sel=3, en=1, one valid 0xA5 -> out_valid=1 with out_data=0xA5 exactly 3 edges later, for one cycle; valid_cnt goes 1,1,1,1 then 0.
REQ-031 Bench: dly_sel=2, 0x11 sent, then en=0 for 5 cycles -> output delayed by 5 extra cycles; valid_cnt held at 1 throughout the stall.
REQ-032 Bench: fill with 0x01..0x04, then flush=1 together with in_valid=1 (0xFF) -> next cycle valid_cnt=0, out_valid=0, 0xFF never appears at the output.
REQ-033 Bench: continuous valid stream with dly_sel=4 -> valid_cnt saturates at 4; switching dly_sel 4->1 mid-stream shows the stage-1 word in the same cycle.
REQ-034 Bench: dly_sel=0 -> out_data tracks in_data combinationally; in_valid=0 with in_data=0x5A -> out_data=0; dly_sel=7 behaves as 4.
REQ-035 Bench: rst driven low between clock edges with 3 entries in flight -> outputs and valid_cnt=0 before the next edge; no stale data appears after release.

Source files
------------

// File: rtl/valid_delay_pipe.sv
// ---------------------------------------------------------------------------
// valid_delay_pipe
//
// Purpose:
//   A DEPTH-stage shift pipeline of (valid, data) pairs with a runtime
//   selectable output tap. Stage 0 is the live input and stages 1..DEPTH are
//   registered. The pipe advances only when en=1. flush clears every stage
//   synchronously. A registered count of the valid entries in stages 1..DEPTH
//   is kept alongside the pipe.
//
//   Invalid stages always hold zero data. This keeps the output data at zero
//   whenever the selected tap is not valid.
//
// Parameters:
//   DEPTH     number of register stages (>= 1)
//   WIDTH     data bus width (>= 1)
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   en         advance enable (1 = shift, 0 = hold and drop the input)
//   flush      synchronous clear of all stages; wins over en
//   in_valid   qualifier for in_data
//   in_data    word entering stage 1
//   dly_sel    output tap 0..DEPTH; larger values clamp to DEPTH
//   out_valid  valid flag at the selected tap (combinational)
//   out_data   data at the selected tap; zero when out_valid=0
//   valid_cnt  registered number of valid entries in stages 1..DEPTH
// ---------------------------------------------------------------------------
module valid_delay_pipe #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int SW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SW-1:0]    dly_sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [SW-1:0]    valid_cnt
);

   localparam logic [SW-1:0] DEPTH_SEL = SW'(DEPTH);

   // Stage registers. Index k is stage k, for k = 1..DEPTH.
   logic [DEPTH:1]   valid_q;
   logic [DEPTH:1]   valid_d;
   logic [WIDTH-1:0] data_q [1:DEPTH];
   logic [WIDTH-1:0] data_d [1:DEPTH];
   logic [SW-1:0]    valid_cnt_q;
   logic [SW-1:0]    valid_cnt_d;

   // Tap view. Index 0 is the live input and 1..DEPTH are the registers.
   logic [DEPTH:0]   tap_valid;
   logic [WIDTH-1:0] tap_data [0:DEPTH];
   logic [SW-1:0]    sel_clamped;

   // Next-state logic for the stages and the occupancy counter.
   // The counter is updated incrementally from what enters stage 1 and what
   // leaves stage DEPTH. It is not recomputed as a popcount, so it stays
   // cheap for deep pipes. Data is zeroed whenever the incoming valid is 0,
   // which keeps the "invalid means zero data" property an invariant.
   always_comb begin
      valid_d     = valid_q;
      data_d      = data_q;
      valid_cnt_d = valid_cnt_q;

      if (flush) begin
         valid_d     = '0;
         valid_cnt_d = '0;
         for (int k = 1; k <= DEPTH; k++) begin
            data_d[k] = '0;
         end
      end else if (en) begin
         valid_d[1] = in_valid;
         data_d[1]  = in_valid ? in_data : '0;
         for (int k = 2; k <= DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = valid_q[k-1] ? data_q[k-1] : '0;
         end

         case ({in_valid, valid_q[DEPTH]})
            2'b10:   valid_cnt_d = valid_cnt_q + SW'(1);
            2'b01:   valid_cnt_d = valid_cnt_q - SW'(1);
            default: valid_cnt_d = valid_cnt_q;
         endcase
      end
   end

   // State registers. Reset discards every in-flight entry immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= '0;
         valid_cnt_q <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q     <= valid_d;
         valid_cnt_q <= valid_cnt_d;
         for (int k = 1; k <= DEPTH; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   // Build the tap array. Stage 0 applies the same zero-when-invalid rule
   // as the registered stages, so the output mux needs no special case.
   always_comb begin
      tap_valid[0] = in_valid;
      tap_data[0]  = in_valid ? in_data : '0;
      for (int k = 1; k <= DEPTH; k++) begin
         tap_valid[k] = valid_q[k];
         tap_data[k]  = data_q[k];
      end
   end

   // Clamp the tap select to DEPTH.
   always_comb begin
      sel_clamped = (dly_sel > DEPTH_SEL) ? DEPTH_SEL : dly_sel;
   end

   // Combinational output mux. A change of dly_sel is visible in the same
   // cycle and does not disturb the stored entries.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      for (int k = 0; k <= DEPTH; k++) begin
         if (sel_clamped == SW'(k)) begin
            out_valid = tap_valid[k];
            out_data  = tap_valid[k] ? tap_data[k] : '0;
         end
      end
   end

   assign valid_cnt = valid_cnt_q;

endmodule

// File: tb/tb_valid_delay_pipe.sv
// ---------------------------------------------------------------------------
// tb_valid_delay_pipe
//
// Purpose:
//   Self-checking bench for valid_delay_pipe with DEPTH=4 and WIDTH=8. A
//   behavioural model of the pipe, kept as a plain array of words, is
//   advanced once per rising edge. Every step compares the DUT outputs
//   against that model, and directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_valid_delay_pipe;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;
   localparam int SW    = 3;

   logic             clk;
   logic             rst;
   logic             en;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic [SW-1:0]    dly_sel;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [SW-1:0]    valid_cnt;

   int total_cnt = 0;
   int pass_cnt  = 0;

   // Reference model. Entry k holds what the word sitting k advances deep
   // looks like. Invalid entries carry zero.
   logic             m_valid [1:DEPTH];
   logic [WIDTH-1:0] m_data  [1:DEPTH];

   bit seen_ff;

   valid_delay_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .dly_sel   (dly_sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .valid_cnt (valid_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_clear();
      for (int k = 1; k <= DEPTH; k++) begin
         m_valid[k] = 1'b0;
         m_data[k]  = '0;
      end
   endtask

   // Compare the live outputs with the model, using the current inputs.
   task automatic check_outputs(input string tag);
      int               idx;
      int               pop;
      logic             ev;
      logic [WIDTH-1:0] ed;
      idx = (int'(dly_sel) > DEPTH) ? DEPTH : int'(dly_sel);
      if (idx == 0) begin
         ev = in_valid;
         ed = in_valid ? in_data : '0;
      end else begin
         ev = m_valid[idx];
         ed = m_valid[idx] ? m_data[idx] : '0;
      end
      pop = 0;
      for (int k = 1; k <= DEPTH; k++) pop += int'(m_valid[k]);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, ".out_data"},  32'(out_data),  32'(ed));
      chk({tag, ".valid_cnt"}, 32'(valid_cnt), 32'(pop));
      if (out_valid && out_data == 8'hFF) seen_ff = 1'b1;
   endtask

   // Advance the model the way the pipe is defined to behave on an edge.
   task automatic model_edge();
      if (flush) begin
         model_clear();
      end else if (en) begin
         for (int k = DEPTH; k >= 2; k--) begin
            m_valid[k] = m_valid[k-1];
            m_data[k]  = m_data[k-1];
         end
         m_valid[1] = in_valid;
         m_data[1]  = in_valid ? in_data : '0;
      end
   endtask

   // One clock cycle: drive after the falling edge, check before the rising
   // edge, then advance the model on the rising edge.
   task automatic applyStimulus(input string tag, input logic v, input logic [7:0] d,
                                input logic e, input logic f, input logic [2:0] s);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      en       = e;
      flush    = f;
      dly_sel  = s;
      #2;
      check_outputs(tag);
      @(posedge clk);
      model_edge();
   endtask

   initial begin
      rst      = 1'b0;
      en       = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      dly_sel  = 3'd3;
      seen_ff  = 1'b0;
      model_clear();

      // Reset state
      #2;
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.out_data",  32'(out_data),  32'd0);
      chk("reset.valid_cnt", 32'(valid_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // A single 0xA5 at tap 3 appears exactly three edges later.
      applyStimulus("a5.push", 1'b1, 8'hA5, 1'b1, 1'b0, 3'd3);
      for (int i = 0; i < 2; i++) begin
         applyStimulus("a5.wait", 1'b0, 8'h00, 1'b1, 1'b0, 3'd3);
         chk("a5.cnt_hold", 32'(valid_cnt), 32'd1);
      end
      applyStimulus("a5.out", 1'b0, 8'h00, 1'b1, 1'b0, 3'd3);
      chk("a5.literal", 32'({out_valid, out_data}), 32'h1A5);
      applyStimulus("a5.after", 1'b0, 8'h00, 1'b1, 1'b0, 3'd3);
      applyStimulus("a5.gone", 1'b0, 8'h00, 1'b1, 1'b0, 3'd3);
      chk("a5.cnt_zero", 32'(valid_cnt), 32'd0);

      // A stall of five cycles at tap 2.
      applyStimulus("stall.push", 1'b1, 8'h11, 1'b1, 1'b0, 3'd2);
      for (int i = 0; i < 5; i++) begin
         applyStimulus("stall.hold", 1'b1, 8'h77, 1'b0, 1'b0, 3'd2);
         chk("stall.cnt", 32'(valid_cnt), 32'd1);
      end
      applyStimulus("stall.move", 1'b0, 8'h00, 1'b1, 1'b0, 3'd2);
      applyStimulus("stall.out", 1'b0, 8'h00, 1'b1, 1'b0, 3'd2);
      chk("stall.literal", 32'({out_valid, out_data}), 32'h111);
      applyStimulus("stall.drain", 1'b0, 8'h00, 1'b1, 1'b0, 3'd2);
      applyStimulus("stall.drain", 1'b0, 8'h00, 1'b1, 1'b0, 3'd2);

      // Fill the pipe, then flush while offering 0xFF.
      seen_ff = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus("fill", 1'b1, 8'(i), 1'b1, 1'b0, 3'd4);
      end
      applyStimulus("flush.edge", 1'b1, 8'hFF, 1'b1, 1'b1, 3'd4);
      for (int s = 1; s <= 4; s++) begin
         applyStimulus("flush.after", 1'b0, 8'h00, 1'b1, 1'b0, 3'(s));
         chk("flush.no_valid", 32'(out_valid), 32'd0);
      end
      chk("flush.no_ff", 32'(seen_ff), 32'd0);

      // A continuous stream saturates the counter, then the tap moves 4 -> 1.
      for (int i = 0; i < 7; i++) begin
         applyStimulus("stream", 1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 3'd4);
      end
      chk("stream.sat", 32'(valid_cnt), 32'd4);
      @(negedge clk);
      dly_sel = 3'd1;
      #1;
      check_outputs("stream.sel1");
      chk("stream.stage1", 32'(out_data), 32'h36);
      @(posedge clk);
      model_edge();

      // Tap 0 is a combinational bypass, and tap 7 clamps to 4.
      applyStimulus("sel0.valid", 1'b1, 8'h3C, 1'b0, 1'b0, 3'd0);
      chk("sel0.literal", 32'(out_data), 32'h3C);
      applyStimulus("sel0.inval", 1'b0, 8'h5A, 1'b0, 1'b0, 3'd0);
      chk("sel0.zero", 32'(out_data), 32'h00);
      applyStimulus("sel7", 1'b0, 8'h00, 1'b0, 1'b0, 3'd7);
      chk("sel7.clamp", 32'(out_data), 32'(m_data[4]));

      // Reset between edges with three entries in flight.
      applyStimulus("rst.flush", 1'b0, 8'h00, 1'b1, 1'b1, 3'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("rst.fill", 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 3'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #2;
      model_clear();
      chk("rst.mid.out_valid", 32'(out_valid), 32'd0);
      chk("rst.mid.out_data",  32'(out_data),  32'd0);
      chk("rst.mid.valid_cnt", 32'(valid_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int s = 1; s <= 4; s++) begin
         applyStimulus("rst.after", 1'b0, 8'h00, 1'b1, 1'b0, 3'(s));
         chk("rst.stale", 32'(out_valid), 32'd0);
      end

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++) begin
         applyStimulus("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                       3'($urandom_range(0, 7)));
      end

      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
